mcdt_nch: RTL and testbench

- Parametrised next-generation multi-channel data transfer block: NCH input channels, each with its own FIFO, merged onto one output stream tagged with the source channel id.
- Adds over the 3-channel version:
  - configurable channel count, data width and FIFO depth
  - downstream backpressure (mcdt_ready_i)
  - run-time selectable fixed-priority or round-robin arbitration
- Sits between channel producers and a single downstream consumer.

---
 rtl/mcdt_pkg.sv | 14 +
 rtl/mcdt_fifo.sv | 55 +++++
 rtl/mcdt_nch.sv | 120 ++++++++++++
 tb/tb_mcdt_nch.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcdt_pkg.sv
// Shared types and default constants for the multi-channel data transfer block.
package mcdt_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int MCDT_DW         = 32;
  localparam int MCDT_NCH        = 3;
  localparam int MCDT_FIFO_DEPTH = 32;
  localparam int DROP_CNT_W      = 16;

endpackage

// File: rtl/mcdt_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible whenever the FIFO is non-empty.
module mcdt_fifo #(
  parameter  int DW         = 32,
  parameter  int FIFO_DEPTH = 32,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int MW         = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [MW-1:0] margin
);

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [MW-1:0] count;
  logic          wr_fire;
  logic          rd_fire;

  // A write into a full FIFO is refused even if a read frees a slot the same cycle.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == MW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign margin  = MW'(FIFO_DEPTH) - count;

endmodule

// File: rtl/mcdt_nch.sv
// NCH-channel FIFO merge with fixed/round-robin arbitration and downstream backpressure.
// Define MCDT_DROP_CNT_EN to add per-channel saturating drop counters on drop_cnt_o.
module mcdt_nch
  import mcdt_pkg::*;
#(
  parameter  int NCH        = MCDT_NCH,
  parameter  int DW         = MCDT_DW,
  parameter  int FIFO_DEPTH = MCDT_FIFO_DEPTH,
  localparam int IDW        = ($clog2(NCH) > 1) ? $clog2(NCH) : 1,
  localparam int MW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NCH*DW-1:0] ch_data_i,
  input  logic [NCH-1:0]    ch_valid_i,
  output logic [NCH-1:0]    ch_ready_o,
  output logic [NCH*MW-1:0] ch_margin_o,
  input  logic              arb_mode_i,
  output logic [DW-1:0]     mcdt_data_o,
  output logic              mcdt_val_o,
  output logic [IDW-1:0]    mcdt_id_o,
  input  logic              mcdt_ready_i
`ifdef MCDT_DROP_CNT_EN
  ,
  output logic [NCH*DROP_CNT_W-1:0] drop_cnt_o
`endif
);

  logic [DW-1:0]  head [NCH];
  logic [NCH-1:0] full;
  logic [NCH-1:0] empty;
  logic [NCH-1:0] pop;
  logic [IDW-1:0] rr_ptr;
  logic           slot_free;
  logic           grant_valid;
  logic           grant_fire;
  logic [IDW-1:0] grant_id;
  logic [DW-1:0]  grant_data;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mcdt_fifo #(
      .DW         (DW),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk_i),
      .rst     (rst_i),
      .wr_en   (ch_valid_i[g]),
      .wr_data (ch_data_i[g*DW +: DW]),
      .rd_en   (pop[g]),
      .rd_data (head[g]),
      .full    (full[g]),
      .empty   (empty[g]),
      .margin  (ch_margin_o[g*MW +: MW])
    );
    assign pop[g] = grant_fire && (grant_id == IDW'(g));
  end

  assign ch_ready_o = ~full;
  assign slot_free  = !mcdt_val_o || mcdt_ready_i;
  assign grant_fire = slot_free && grant_valid;

  // Round robin first scans channels above the pointer, then wraps to a plain
  // lowest-index scan, which is also the whole of fixed-priority mode.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    grant_data  = '0;
    if (arb_mode_e'(arb_mode_i) == ARB_RR) begin
      for (int j = 0; j < NCH; j++) begin
        if (!grant_valid && !empty[j] && (j > int'(rr_ptr))) begin
          grant_valid = 1'b1;
          grant_id    = IDW'(j);
          grant_data  = head[j];
        end
      end
    end
    for (int j = 0; j < NCH; j++) begin
      if (!grant_valid && !empty[j]) begin
        grant_valid = 1'b1;
        grant_id    = IDW'(j);
        grant_data  = head[j];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcdt_val_o  <= 1'b0;
      mcdt_data_o <= '0;
      mcdt_id_o   <= '0;
      rr_ptr      <= IDW'(NCH - 1);
    end else if (slot_free) begin
      mcdt_val_o <= grant_valid;
      if (grant_valid) begin
        mcdt_data_o <= grant_data;
        mcdt_id_o   <= grant_id;
        rr_ptr      <= grant_id;
      end
    end
  end

`ifdef MCDT_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt [NCH];

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst_i) begin
        drop_cnt[i] <= '0;
      end else if (ch_valid_i[i] && full[i] && (drop_cnt[i] != '1)) begin
        drop_cnt[i] <= drop_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_drop
    assign drop_cnt_o[g*DROP_CNT_W +: DROP_CNT_W] = drop_cnt[g];
  end
`endif

endmodule

// File: tb/tb_mcdt_nch.sv
// Scoreboard bench for mcdt_nch: stimulus pushes expected {id,data}, a monitor pops on each handshake.
module tb_mcdt_nch;
  import mcdt_pkg::*;

  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int FD  = 32;
  localparam int IDW = 2;
  localparam int MW  = 6;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NCH*DW-1:0] ch_data_i;
  logic [NCH-1:0]    ch_valid_i;
  logic [NCH-1:0]    ch_ready_o;
  logic [NCH*MW-1:0] ch_margin_o;
  logic              arb_mode_i;
  logic [DW-1:0]     mcdt_data_o;
  logic              mcdt_val_o;
  logic [IDW-1:0]    mcdt_id_o;
  logic              mcdt_ready_i;
`ifdef MCDT_DROP_CNT_EN
  logic [NCH*16-1:0] drop_cnt_o;
`endif

  int checks    = 0;
  int failures  = 0;
  int stale_cnt = 0;
  logic watch_stale = 1'b0;
  logic [IDW+DW-1:0] sb [$];

  mcdt_nch #(.NCH(NCH), .DW(DW), .FIFO_DEPTH(FD)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .ch_data_i    (ch_data_i),
    .ch_valid_i   (ch_valid_i),
    .ch_ready_o   (ch_ready_o),
    .ch_margin_o  (ch_margin_o),
    .arb_mode_i   (arb_mode_i),
    .mcdt_data_o  (mcdt_data_o),
    .mcdt_val_o   (mcdt_val_o),
    .mcdt_id_o    (mcdt_id_o),
    .mcdt_ready_i (mcdt_ready_i)
`ifdef MCDT_DROP_CNT_EN
    ,
    .drop_cnt_o   (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int c, input int i);
    return 32'h00C0_0000 + (32'(c) << 16) + 32'(i);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drives the masked channels with back-to-back words 0..n-1 of their own sequence.
  task automatic applyStimulus(input logic [NCH-1:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < NCH; c++) ch_data_i[c*DW +: DW] = word(c, i);
      ch_valid_i = mask;
      @(posedge clk);
      #1;
    end
    ch_valid_i = '0;
  endtask

  task automatic pushRange(input int c, input int first, input int cnt);
    for (int i = 0; i < cnt; i++) sb.push_back({IDW'(c), word(c, first + i)});
  endtask

  task automatic pushInterleaved(input int per_ch);
    for (int w = 0; w < per_ch; w++)
      for (int c = 0; c < NCH; c++) sb.push_back({IDW'(c), word(c, w)});
  endtask

  task automatic waitDrain(input string name);
    for (int k = 0; k < 500; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    checkOutput(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  // Handshake monitor: every accepted output word must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst_i && watch_stale && mcdt_val_o) stale_cnt++;
    if (!rst_i && mcdt_val_o && mcdt_ready_i) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_word", {30'd0, mcdt_id_o, mcdt_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [IDW+DW-1:0] exp;
        exp = sb.pop_front();
        checkOutput("out_word", 64'({mcdt_id_o, mcdt_data_o}), 64'(exp));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_i        = 1'b1;
    ch_data_i    = '0;
    ch_valid_i   = '0;
    arb_mode_i   = ARB_FIXED;
    mcdt_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst_i = 1'b0;

    @(negedge clk);
    checkOutput("rst_ready", 64'(ch_ready_o), 64'h7);
    for (int c = 0; c < NCH; c++) checkOutput("rst_margin", 64'(ch_margin_o[c*MW +: MW]), 64'd32);
    checkOutput("rst_val", 64'(mcdt_val_o), 64'd0);
    checkOutput("rst_id", 64'(mcdt_id_o), 64'd0);
    checkOutput("rst_data", 64'(mcdt_data_o), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] single channel stream on ch1");
    pushRange(1, 0, 10);
    fork
      applyStimulus(3'b010, 10);
      begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("latency_before", 64'(mcdt_val_o), 64'd0);
        @(negedge clk);
        checkOutput("latency_after", 64'(mcdt_val_o), 64'd1);
      end
    join
    waitDrain("single_drain");
    @(negedge clk);
    checkOutput("single_margin", 64'(ch_margin_o[1*MW +: MW]), 64'd32);
    checkOutput("single_idle_val", 64'(mcdt_val_o), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] fill ch0 under backpressure");
    mcdt_ready_i = 1'b0;
    applyStimulus(3'b001, 34);
    pushRange(0, 0, 33);
    @(negedge clk);
    checkOutput("bp_val", 64'(mcdt_val_o), 64'd1);
    checkOutput("bp_data", 64'(mcdt_data_o), 64'h00C0_0000);
    checkOutput("bp_id", 64'(mcdt_id_o), 64'd0);
    checkOutput("bp_full_ready", 64'(ch_ready_o), 64'h6);
    checkOutput("bp_margin", 64'(ch_margin_o[0 +: MW]), 64'd0);
`ifdef MCDT_DROP_CNT_EN
    checkOutput("bp_drop_cnt", 64'(drop_cnt_o[0 +: 16]), 64'd1);
`endif
    @(posedge clk);
    #1;
    mcdt_ready_i = 1'b1;
    waitDrain("bp_drain");
    @(negedge clk);
    checkOutput("bp_margin_back", 64'(ch_margin_o[0 +: MW]), 64'd32);
    checkOutput("bp_ready_back", 64'(ch_ready_o), 64'h7);
    @(posedge clk);
    #1;

    $display("[TB] round robin drain");
    pulseReset();
    arb_mode_i   = ARB_RR;
    mcdt_ready_i = 1'b0;
    applyStimulus(3'b111, 4);
    pushInterleaved(4);
    @(negedge clk);
    checkOutput("rr_held", 64'({mcdt_val_o, mcdt_id_o, mcdt_data_o}), 64'({1'b1, 2'd0, 32'h00C0_0000}));
    @(posedge clk);
    #1;
    mcdt_ready_i = 1'b1;
    waitDrain("rr_drain");

    $display("[TB] fixed priority drain");
    pulseReset();
    arb_mode_i   = ARB_FIXED;
    mcdt_ready_i = 1'b0;
    applyStimulus(3'b111, 4);
    for (int c = 0; c < NCH; c++) pushRange(c, 0, 4);
    @(posedge clk);
    #1;
    mcdt_ready_i = 1'b1;
    waitDrain("fixed_drain");

    $display("[TB] reset in the middle of a round robin drain");
    pulseReset();
    arb_mode_i   = ARB_RR;
    mcdt_ready_i = 1'b0;
    applyStimulus(3'b111, 4);
    pushInterleaved(4);
    @(posedge clk);
    #1;
    mcdt_ready_i = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checkOutput("midrst_consumed", 64'(sb.size()), 64'd8);
    pulseReset();
    sb.delete();
    watch_stale = 1'b1;
    @(negedge clk);
    checkOutput("midrst_val", 64'(mcdt_val_o), 64'd0);
    for (int c = 0; c < NCH; c++) checkOutput("midrst_margin", 64'(ch_margin_o[c*MW +: MW]), 64'd32);
    repeat (20) @(negedge clk);
    watch_stale = 1'b0;
    checkOutput("midrst_no_stale", 64'(stale_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
